// File: rtl/mem_march_initiator.sv
// mem_march_initiator: march BIST initiator; writes pattern to all words, reads back, reports errors. Ports: clk/rst, start/invert control, busy/done/pass/err_count/first_err_addr status, mem_* bus.
module mem_march_initiator #(
  parameter int DW = 8,
  parameter int AW = 5,
  parameter logic [DW-1:0] SEED = DW'(8'hA5)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          invert,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [AW-1:0] LAST = '1;
  state_t state;
  logic inv, cmp_valid;
  logic [DW-1:0] exp_q;
  logic [AW-1:0] cmp_addr;
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic i);
    return DW'(a) ^ SEED ^ {DW{i}};
  endfunction
  assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done = state == DONE;
  assign pass = done && (err_count == '0);
  // mem_addr doubles as the address counter; it is 0 outside WRITE/READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inv <= 1'b0;
      cmp_valid <= 1'b0;
      exp_q <= '0;
      cmp_addr <= '0;
      err_count <= '0;
      first_err_addr <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      mem_data_in <= '0;
    end else begin
      // err_count is zero until the first mismatch, so it doubles as the err flag.
      if (cmp_valid && mem_data_out != exp_q) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= cmp_addr;
      end
      cmp_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= WRITE;
          inv <= invert;
          mem_write <= 1'b1;
          mem_addr <= '0;
          mem_data_in <= pat('0, invert);
          err_count <= '0;
          first_err_addr <= '0;
        end
        WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          mem_data_in <= pat(mem_addr + 1'b1, inv);
          if (mem_addr == LAST) begin
            state <= READ;
            mem_write <= 1'b0;
            mem_read <= 1'b1;
            mem_data_in <= '0;
          end
        end
        READ: begin
          cmp_valid <= 1'b1;
          exp_q <= pat(mem_addr, inv);
          cmp_addr <= mem_addr;
          mem_addr <= mem_addr + 1'b1;
          if (mem_addr == LAST) begin
            state <= DRAIN;
            mem_read <= 1'b0;
          end
        end
        DRAIN: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_march_initiator.sv
// tb_mem_march_initiator: scoreboard bench for mem_march_initiator with a behavioural memory and read-fault injection.
module tb_mem_march_initiator;
  logic clk = 0, rst = 0, start = 0, invert = 0;
  logic busy, done, pass, mem_write, mem_read;
  logic [5:0] err_count;
  logic [4:0] first_err_addr, mem_addr;
  logic [7:0] mem_data_in, mem_data_out;
  logic [7:0] mem [32];
  logic [31:0] flip = '0;
  int vecs = 0, errs = 0;
  logic [7:0] w0, w3, w31;
  always #5 clk = ~clk;
  mem_march_initiator dut (
    .clk(clk), .rst(rst), .start(start), .invert(invert), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addr] ^ {7'b0, flip[mem_addr]};
  end
  task automatic run(input logic iv, input int tog, input int srd, input logic [31:0] fl);
    logic [7:0] wq[$];
    logic [7:0] d;
    int exp_err = 0;
    int exp_first = -1;
    flip = fl;
    for (int a = 0; a < 32; a++) if (fl[a]) begin
      exp_err++;
      if (exp_first < 0) exp_first = a;
    end
    if (exp_first < 0) exp_first = 0;
    @(negedge clk);
    start = 1;
    invert = iv;
    for (int a = 0; a < 32; a++) wq.push_back(8'(a) ^ 8'hA5 ^ {8{iv}});
    @(negedge clk);
    start = 0;
    vecs++;
    if (done !== 1'b0 || err_count !== 6'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL start_edge: done=%b err_count=%0d busy=%b, required done=0 err_count=0 busy=1", done, err_count, busy);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == tog) invert = ~invert;
      d = wq.pop_front();
      vecs++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 5'(i) || mem_data_in !== d) begin
        errs++;
        $display("FAIL write%0d: we=%b re=%b addr=%0d data=%h, required we=1 re=0 addr=%0d data=%h", i, mem_write, mem_read, mem_addr, mem_data_in, i, d);
      end
      if (i == 0) w0 = mem_data_in;
      if (i == 3) w3 = mem_data_in;
      if (i == 31) w31 = mem_data_in;
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) begin
      start = (i == srd);
      vecs++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 5'(i) || busy !== 1'b1 || mem_data_in !== 8'h00) begin
        errs++;
        $display("FAIL read%0d: re=%b we=%b addr=%0d busy=%b din=%h, required re=1 we=0 addr=%0d busy=1 din=00", i, mem_read, mem_write, mem_addr, busy, mem_data_in, i);
      end
      @(negedge clk);
    end
    start = 0;
    vecs++;
    if (busy !== 1'b1 || done !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 5'd0) begin
      errs++;
      $display("FAIL drain: busy=%b done=%b re=%b addr=%0d, required busy=1 done=0 re=0 addr=0", busy, done, mem_read, mem_addr);
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 0) || err_count !== 6'(exp_err) || first_err_addr !== 5'(exp_first)) begin
      errs++;
      $display("FAIL done: done=%b busy=%b pass=%b err=%0d first=%0d, required done=1 busy=0 pass=%b err=%0d first=%0d",
               done, busy, pass, err_count, first_err_addr, exp_err == 0, exp_err, exp_first);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    vecs++;
    if ({busy, done, pass, mem_write, mem_read} !== 5'b0 || err_count !== 6'd0 || mem_addr !== 5'd0 || mem_data_in !== 8'd0) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b pass=%b we=%b re=%b err=%0d addr=%0d, required all 0", busy, done, pass, mem_write, mem_read, err_count, mem_addr);
    end
  endtask
  task automatic test_clean;
    run(1'b0, -1, -1, 32'h0);
    vecs++;
    if (w0 !== 8'hA5 || w31 !== 8'hBA) begin
      errs++;
      $display("FAIL clean_pattern: addr0=%h addr31=%h, required A5 BA", w0, w31);
    end
  endtask
  task automatic test_faults;
    run(1'b0, -1, -1, (32'h1 << 7) | (32'h1 << 20));
  endtask
  task automatic test_invert;
    run(1'b1, 2, 10, 32'h0);
    vecs++;
    if (w0 !== 8'h5A || w3 !== 8'h59) begin
      errs++;
      $display("FAIL invert_pattern: addr0=%h addr3=%h, required 5A 59", w0, w3);
    end
  endtask
  task automatic test_mid_reset;
    @(negedge clk);
    start = 1;
    invert = 0;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    vecs++;
    if (mem_addr !== 5'd10 || mem_write !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset: addr=%0d we=%b, required addr=10 we=1", mem_addr, mem_write);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    vecs++;
    if (busy !== 1'b0 || mem_write !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd0 || err_count !== 6'd0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b we=%b done=%b addr=%0d err=%0d, required all 0", busy, mem_write, done, mem_addr, err_count);
    end
  endtask
  task automatic test_back_to_back;
    run(1'b0, -1, -1, (32'h1 << 7) | (32'h1 << 20));
    run(1'b0, -1, -1, 32'h0);
  endtask
  initial begin
    test_reset;
    test_clean;
    test_faults;
    test_invert;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
